// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: byte-event detection, FWFT byte FIFO, receiver flow control and sticky status.
// Optional idle timeout (rx_idle output, IDLE_TIMEOUT parameter) is built when UART_RX_CTRL_TIMEOUT_EN is defined.
//
// state | meaning
// ------+------------------------------------------------------------
// OFF   | receiver disabled by software
// RUN   | receiver enabled, FIFO has room
// FULL  | receiver paused until FIFO drains to RESUME_LEVEL
// BRK   | locked out after a BREAK until clear
module uart_rx_ctrl #(
   parameter int FIFO_DEPTH   = 8,
   parameter int FIFO_AW      = 3,
   parameter int RESUME_LEVEL = 4
`ifdef UART_RX_CTRL_TIMEOUT_EN
   ,
   parameter int IDLE_TIMEOUT = 1000
`endif
) (
`ifdef UART_RX_CTRL_TIMEOUT_EN
   output logic               rx_idle,
`endif
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               clear,
   input  logic               rx_valid,
   input  logic [7:0]         rx_data,
   input  logic               rx_break,
   output logic               rx_en,
   output logic               out_valid,
   output logic [7:0]         out_data,
   input  logic               out_ready,
   output logic [FIFO_AW:0]   fifo_count,
   output logic               overflow,
   output logic               break_seen
);

   localparam int CW = FIFO_AW + 1;

   typedef enum logic [1:0] {S_OFF, S_RUN, S_FULL, S_BRK} state_t;

   state_t             state;
   state_t             state_next;
   logic               rx_valid_q;
   logic               rx_break_q;
   logic [7:0]         mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [FIFO_AW:0]   count_next;
   logic               evt;
   logic               brk_evt;
   logic               byte_evt;
   logic               pop;
   logic               push;
   logic               drop;

   assign evt      = rx_valid_q && !rx_valid;
   assign brk_evt  = evt && rx_break_q;
   assign byte_evt = evt && !rx_break_q;

   assign out_valid = (fifo_count != '0);
   assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;
   assign pop       = out_valid && out_ready;
   // A same-cycle pop frees the slot, so a full FIFO can still accept.
   assign push      = byte_evt && ((fifo_count < CW'(FIFO_DEPTH)) || pop);
   assign drop      = byte_evt && !push;

   always_comb begin
      count_next = fifo_count;
      case ({push, pop})
         2'b10:   count_next = fifo_count + CW'(1);
         2'b01:   count_next = fifo_count - CW'(1);
         default: count_next = fifo_count;
      endcase
   end

   always_comb begin
      state_next = state;
      rx_en      = 1'b0;
      case (state)
         S_OFF: begin
            if (enable) state_next = S_RUN;
         end
         S_RUN: begin
            rx_en = 1'b1;
            if (brk_evt)                                  state_next = S_BRK;
            else if (!enable)                             state_next = S_OFF;
            else if (count_next >= CW'(FIFO_DEPTH - 1))   state_next = S_FULL;
         end
         S_FULL: begin
            if (brk_evt)                                  state_next = S_BRK;
            else if (!enable)                             state_next = S_OFF;
            else if (fifo_count <= CW'(RESUME_LEVEL))     state_next = S_RUN;
         end
         S_BRK: begin
            if (clear) state_next = enable ? S_RUN : S_OFF;
         end
         default: state_next = S_OFF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_OFF;
         rx_valid_q <= 1'b0;
         rx_break_q <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
         break_seen <= 1'b0;
      end else begin
         state      <= state_next;
         rx_valid_q <= rx_valid;
         rx_break_q <= rx_break;
         fifo_count <= count_next;
         if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
         if (drop)        overflow <= 1'b1;
         else if (clear)  overflow <= 1'b0;
         if (brk_evt)     break_seen <= 1'b1;
         else if (clear)  break_seen <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= rx_data;
   end

`ifdef UART_RX_CTRL_TIMEOUT_EN
   localparam int IW = $clog2(IDLE_TIMEOUT + 1);

   logic [IW-1:0] idle_cnt;

   // Counter saturates at IDLE_TIMEOUT so rx_idle fires once per idle stretch.
   always_ff @(posedge clk) begin
      if (reset) begin
         idle_cnt <= '0;
         rx_idle  <= 1'b0;
      end else begin
         rx_idle <= 1'b0;
         if (evt || (fifo_count == '0)) begin
            idle_cnt <= '0;
         end else if (idle_cnt != IW'(IDLE_TIMEOUT)) begin
            idle_cnt <= idle_cnt + IW'(1);
            rx_idle  <= (idle_cnt == IW'(IDLE_TIMEOUT - 1));
         end
      end
   end
`endif

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side controller sitting between the uart_rx byte receiver and the system consumer.
- Sequences the receiver through recv_en: start/stop, FIFO-driven flow control, and lock-out after a BREAK.
- Turns the receiver's multi-cycle recv_valid level into single byte events and buffers bytes in a first-word-fall-through FIFO with a valid/ready output.
- Keeps sticky overflow and break status for software.

Parameters:
- FIFO_DEPTH, 8: number of byte entries; power of 2, minimum 4.
- FIFO_AW, 3: log2(FIFO_DEPTH).
- RESUME_LEVEL, 4: when FIFO occupancy is at or below this level, the FULL state returns to RUN; must be below FIFO_DEPTH-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  software receive enable.
- clear  in  1  single-cycle pulse; clears sticky flags and releases BRK.
- rx_valid  in  1  from receiver recv_valid; high for a whole stop-bit period.
- rx_data  in  8  from receiver recv_data.
- rx_break  in  1  from receiver break.
- rx_en  out  1  to receiver recv_en.
- out_valid  out  1  FIFO head valid.
- out_data  out  8  FIFO head byte.
- out_ready  in  1  consumer accepts the head.
- fifo_count  out  FIFO_AW+1  current occupancy.
- overflow  out  1  sticky: a byte was dropped.
- break_seen  out  1  sticky: a BREAK was received.

Behaviour:
- Byte event:
  - The block registers rx_valid (rx_valid_q) and rx_break (rx_break_q) every cycle.
  - A byte event occurs on the cycle rx_valid_q=1 and rx_valid=0, i.e. the falling edge of rx_valid.
  - The event byte is rx_data on that cycle. The event is a break when rx_break_q=1.
  - Exactly one event per rx_valid high period.
- FIFO:
  - out_valid = (fifo_count != 0); out_data = entry at the read pointer (combinational from storage).
  - Pop when out_valid && out_ready.
  - Push on a non-break byte event when fifo_count < FIFO_DEPTH, or when a pop occurs in the same cycle. On simultaneous push and pop, fifo_count is unchanged and the byte is stored.
  - A non-break event with the FIFO full and no pop drops the byte and sets overflow.
  - Pointers are FIFO_AW bits and wrap naturally. fifo_count is FIFO_AW+1 bits.
- FSM states: OFF, RUN, FULL, BRK.
  - OFF: rx_en=0. Go to RUN when enable=1.
  - RUN: rx_en=1.
    - A break event → BRK.
    - Otherwise, if the next-cycle fifo_count >= FIFO_DEPTH-1 → FULL. This keeps one slot in reserve for a frame already in flight.
  - FULL: rx_en=0. Go to RUN when fifo_count <= RESUME_LEVEL. A break event → BRK.
  - BRK: rx_en=0. Go to RUN when clear=1 and enable=1; go to OFF when clear=1 and enable=0.
  - enable=0 in RUN or FULL → OFF on the next cycle. Priority in those states: break > enable low > level transitions.
- Byte events arriving in any state, including OFF and FULL, are still pushed; this covers frames in flight when rx_en dropped.
- Break events:
  - Never pushed.
  - Set break_seen in every state.
  - Enter BRK only from RUN or FULL.
- Sticky flags:
  - clear zeroes overflow and break_seen.
  - A set condition in the same cycle as clear wins (the flag stays 1).
- Reset: state OFF, rx_en=0, pointers and fifo_count 0, out_valid=0, out_data reads 0, overflow=0, break_seen=0, rx_valid_q=0, rx_break_q=0. Storage contents are don't-care except that out_data is masked to 0 when empty. Reset mid-frame discards everything; the event edge detector restarts.
- Latency: a byte appears on out_valid/out_data one cycle after its byte event.

Optional Feature:
- Macro UART_RX_CTRL_TIMEOUT_EN adds parameter IDLE_TIMEOUT (default 1000, cycles) and output port rx_idle (1 bit).
- An idle counter counts clk cycles while fifo_count != 0 and no byte event occurs. It resets to 0 on any byte event or when the FIFO is empty.
- rx_idle pulses high for one cycle when the counter reaches IDLE_TIMEOUT; the counter then holds until reset by an event or empty FIFO. rx_idle resets to 0.
- Without the macro, the port, parameter and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then enable=1 → rx_en=1 next cycle. Drive rx_valid high 10 cycles with rx_data=0x5A, then low → out_valid=1 and out_data=0x5A one cycle after the fall; out_ready=1 → fifo_count returns to 0.
- out_ready=0, push 7 bytes 0x01..0x07 → rx_en drops after the 7th (FULL). Push 0x08 → accepted, count=8. Push 0x09 → dropped, overflow=1. Pop 4 → count=4, rx_en=1 again. Order of popped bytes is 0x01..0x04.
- FIFO full with out_ready=1 and a byte event in the same cycle → byte stored, count stays 8, overflow stays 0.
- Event with rx_break high during rx_valid and rx_data=0x00 → nothing pushed, break_seen=1, rx_en=0. clear pulse with enable=1 → RUN, break_seen=0.
- enable=0 while rx_valid is high → state OFF, but the byte is still pushed on the fall. Assert reset mid-rx_valid → all outputs at reset values, no event generated afterwards.
- With UART_RX_CTRL_TIMEOUT_EN and IDLE_TIMEOUT=20: push one byte, hold out_ready=0 → rx_idle pulses exactly once, 20 cycles after the push event.
